// File: rtl/ip_rx_protocol.sv
// IPv4 receive parser: checks a 20-byte header arriving as nibbles, then forwards the payload.
// Latency 1 cycle from input nibble to pl_da or status pulse; no backpressure, the stream is never stalled.
module ip_rx_protocol #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_8958
) (
    input  logic        mii_rx_clk,
    input  logic        rst,
    input  logic        mac_dv,
    input  logic [3:0]  mac_da,
    output logic        pl_valid,
    output logic [3:0]  pl_da,
    output logic        pl_last,
    output logic        hdr_ok,
    output logic        hdr_err,
    output logic        trunc_err,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip,
    output logic [15:0] ip_totlen,
    output logic [7:0]  protocol
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [5:0]  nib_cnt_q, nib_cnt_d;
    logic [11:0] wbuf_q, wbuf_d;
    logic [15:0] csum_q, csum_d;
    logic [7:0]  vihl_q, vihl_d;
    logic [15:0] tot_q, tot_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [15:0] dsth_q, dsth_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;

    logic        pl_valid_q, pl_valid_d;
    logic [3:0]  pl_da_q, pl_da_d;
    logic        pl_last_q, pl_last_d;
    logic        hdr_ok_q, hdr_ok_d;
    logic        hdr_err_q, hdr_err_d;
    logic        trunc_q, trunc_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] totlen_q, totlen_d;
    logic [7:0]  proto_o_q, proto_o_d;

    logic [15:0] word;
    logic [16:0] sum_raw;
    logic [15:0] csum_fold;
    logic [31:0] dst_full;
    logic [15:0] pay_len;
    logic        hdr_good;

    // wbuf holds nibbles 4j, 4j+1, 4j+2 (oldest in the top slot); the current nibble completes word j.
    assign word      = {wbuf_q[7:4], wbuf_q[11:8], mac_da, wbuf_q[3:0]};
    assign sum_raw   = {1'b0, csum_q} + {1'b0, word};
    assign csum_fold = sum_raw[15:0] + {15'd0, sum_raw[16]};
    assign dst_full  = {dsth_q, word};
    assign pay_len   = (tot_q - 16'd20) << 1;
    assign hdr_good  = (vihl_q == 8'h45) && (csum_fold == 16'hFFFF) && (tot_q >= 16'd20) &&
                       ((dst_full == LOCAL_IP) || (dst_full == 32'hFFFF_FFFF));

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~mac_dv;
        nib_cnt_d  = nib_cnt_q;
        wbuf_d     = wbuf_q;
        csum_d     = csum_q;
        vihl_d     = vihl_q;
        tot_d      = tot_q;
        proto_d    = proto_q;
        src_d      = src_q;
        dsth_d     = dsth_q;
        pay_cnt_d  = pay_cnt_q;
        pl_valid_d = 1'b0;
        pl_da_d    = pl_da_q;
        pl_last_d  = 1'b0;
        hdr_ok_d   = 1'b0;
        hdr_err_d  = 1'b0;
        trunc_d    = 1'b0;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        totlen_d   = totlen_q;
        proto_o_d  = proto_o_q;

        case (state_q)
            IDLE: begin
                // armed_q blocks parsing of a datagram already in flight when reset released
                if (mac_dv && armed_q) begin
                    state_d   = HDR;
                    nib_cnt_d = 6'd1;
                    wbuf_d    = {wbuf_q[7:0], mac_da};
                    csum_d    = 16'd0;
                end
            end
            HDR: begin
                if (!mac_dv) begin
                    trunc_d   = 1'b1;
                    nib_cnt_d = 6'd0;
                    state_d   = IDLE;
                end else begin
                    wbuf_d    = {wbuf_q[7:0], mac_da};
                    nib_cnt_d = nib_cnt_q + 6'd1;
                    if (nib_cnt_q[1:0] == 2'd3) begin
                        csum_d = csum_fold;
                        case (nib_cnt_q[5:2])
                            4'd0:    vihl_d = word[15:8];
                            4'd1:    tot_d = word;
                            4'd4:    proto_d = word[7:0];
                            4'd6:    src_d[31:16] = word;
                            4'd7:    src_d[15:0] = word;
                            4'd8:    dsth_d = word;
                            default: ;
                        endcase
                    end
                    if (nib_cnt_q == 6'd39) begin
                        nib_cnt_d = 6'd0;
                        if (hdr_good) begin
                            hdr_ok_d  = 1'b1;
                            src_ip_d  = src_q;
                            dst_ip_d  = dst_full;
                            totlen_d  = tot_q;
                            proto_o_d = proto_q;
                            pay_cnt_d = pay_len;
                            state_d   = (pay_len == 16'd0) ? DROP : PAYLOAD;
                        end else begin
                            hdr_err_d = 1'b1;
                            state_d   = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!mac_dv) begin
                    trunc_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    pl_valid_d = 1'b1;
                    pl_da_d    = mac_da;
                    pay_cnt_d  = pay_cnt_q - 16'd1;
                    if (pay_cnt_q == 16'd1) begin
                        pl_last_d = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                // Ethernet padding and rejected datagrams are swallowed here
                if (!mac_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            nib_cnt_q  <= 6'd0;
            wbuf_q     <= 12'd0;
            csum_q     <= 16'd0;
            vihl_q     <= 8'd0;
            tot_q      <= 16'd0;
            proto_q    <= 8'd0;
            src_q      <= 32'd0;
            dsth_q     <= 16'd0;
            pay_cnt_q  <= 16'd0;
            pl_valid_q <= 1'b0;
            pl_da_q    <= 4'd0;
            pl_last_q  <= 1'b0;
            hdr_ok_q   <= 1'b0;
            hdr_err_q  <= 1'b0;
            trunc_q    <= 1'b0;
            src_ip_q   <= 32'd0;
            dst_ip_q   <= 32'd0;
            totlen_q   <= 16'd0;
            proto_o_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            nib_cnt_q  <= nib_cnt_d;
            wbuf_q     <= wbuf_d;
            csum_q     <= csum_d;
            vihl_q     <= vihl_d;
            tot_q      <= tot_d;
            proto_q    <= proto_d;
            src_q      <= src_d;
            dsth_q     <= dsth_d;
            pay_cnt_q  <= pay_cnt_d;
            pl_valid_q <= pl_valid_d;
            pl_da_q    <= pl_da_d;
            pl_last_q  <= pl_last_d;
            hdr_ok_q   <= hdr_ok_d;
            hdr_err_q  <= hdr_err_d;
            trunc_q    <= trunc_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
            totlen_q   <= totlen_d;
            proto_o_q  <= proto_o_d;
        end
    end

    assign pl_valid  = pl_valid_q;
    assign pl_da     = pl_da_q;
    assign pl_last   = pl_last_q;
    assign hdr_ok    = hdr_ok_q;
    assign hdr_err   = hdr_err_q;
    assign trunc_err = trunc_q;
    assign src_ip    = src_ip_q;
    assign dst_ip    = dst_ip_q;
    assign ip_totlen = totlen_q;
    assign protocol  = proto_o_q;

endmodule
